decomp_sequencer: RTL and testbench

Command-level sequencer that sits directly upstream of the vector decomposition controller. It accepts one decomposition command and issues one `start_vector` pulse per digit, each with `operation` set to the decomposition opcode. For digit d it drives shift (`p`) = base_shift + d·bit_cnt and digit width (`pq0`) = bit_cnt. It tracks the controller's `vector_working` to detect each digit's completion, then hands every finished digit to the downstream consumer through a valid/ack handshake before it launches the next one.

---
 rtl/decomp_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_decomp_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_sequencer
//  Description : Command-level sequencer for the vector decomposition
//                controller. Splits one decomposition command into per-digit
//                start_vector launches, times each digit, and hands every
//                finished digit to a downstream consumer via valid/ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module decomp_sequencer #(
    parameter int          FSIZE        = 64,
    parameter int          logD         = 4,
    parameter int          ARM_TIMEOUT  = 64,
    parameter int          CYC_W        = 24,
    parameter logic [3:0]  VECTOR_OPERATION_DECOMP_REDUCTION = 4'd5
) (
    input  logic             clk,
    input  logic             rst,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [logD-1:0]  cmd_num_digits,
    input  logic [FSIZE-1:0] cmd_bit_cnt,
    input  logic [FSIZE-1:0] cmd_base_shift,
    input  logic             abort,
    // vector controller side
    output logic             start_vector,
    output logic [3:0]       operation,
    output logic [FSIZE-1:0] p,
    output logic [FSIZE-1:0] pq0,
    input  logic             vector_working,
    // digit handoff
    output logic             digit_valid,
    output logic [logD-1:0]  digit_idx,
    output logic [CYC_W-1:0] digit_cycles,
    input  logic             digit_ack,
    // status
    output logic             done,
    output logic             err,
    output logic             busy
);

    // Width of the ARM wait counter: must hold ARM_TIMEOUT-1.
    localparam int               ARM_W      = $clog2(ARM_TIMEOUT + 1);
    localparam logic [ARM_W-1:0] c_arm_last = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] c_cyc_max  = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_ARM     = 3'd2,
        S_RUN     = 3'd3,
        S_HANDOFF = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t            state;
    logic [logD-1:0]   r_num_digits;
    logic [FSIZE-1:0]  r_bit_cnt;
    logic [FSIZE-1:0]  r_p;
    logic [FSIZE-1:0]  r_pq0;
    logic [logD-1:0]   r_d;
    logic [CYC_W-1:0]  r_cyc;
    logic [CYC_W-1:0]  r_digit_cycles;
    logic [ARM_W-1:0]  r_arm;
    logic              r_abort_pend;
    logic              r_err;

    logic [CYC_W-1:0]  w_cyc_inc;
    logic              w_last_digit;

    // Saturating increment of the per-digit cycle counter.
    assign w_cyc_inc    = (r_cyc == c_cyc_max) ? r_cyc : r_cyc + 1'b1;
    // Widened compare so d+1 never wraps when num_digits is at its maximum.
    assign w_last_digit = (({1'b0, r_d} + 1'b1) == {1'b0, r_num_digits});

    // Sequencer FSM: command acceptance, per-digit launch, timing and handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            r_num_digits   <= '0;
            r_bit_cnt      <= '0;
            r_p            <= '0;
            r_pq0          <= '0;
            r_d            <= '0;
            r_cyc          <= '0;
            r_digit_cycles <= '0;
            r_arm          <= '0;
            r_abort_pend   <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_num_digits <= cmd_num_digits;
                        r_bit_cnt    <= cmd_bit_cnt;
                        r_err        <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_d          <= '0;
                        if (cmd_bit_cnt == '0) begin
                            // Zero-width digits are meaningless: reject.
                            r_err <= 1'b1;
                            state <= S_FINISH;
                        end else if (cmd_num_digits == '0) begin
                            state <= S_FINISH;
                        end else begin
                            // p/pq0 only move on entry to START so they stay
                            // stable for the whole controller operation.
                            r_p   <= cmd_base_shift;
                            r_pq0 <= cmd_bit_cnt;
                            state <= S_START;
                        end
                    end
                end

                S_START: begin
                    if (abort) begin
                        r_err <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        // Start cycle itself counts as cycle 1 of the digit.
                        r_cyc <= {{(CYC_W-1){1'b0}}, 1'b1};
                        r_arm <= '0;
                        state <= S_ARM;
                    end
                end

                S_ARM: begin
                    r_cyc <= w_cyc_inc;
                    if (vector_working) begin
                        // Controller has started; it cannot be interrupted,
                        // so an abort here is deferred to the end of the digit.
                        if (abort) begin
                            r_abort_pend <= 1'b1;
                        end
                        state <= S_RUN;
                    end else if (abort || (r_arm == c_arm_last)) begin
                        r_err <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        r_arm <= r_arm + 1'b1;
                    end
                end

                S_RUN: begin
                    r_cyc <= w_cyc_inc;
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (!vector_working) begin
                        r_digit_cycles <= w_cyc_inc;
                        if (abort || r_abort_pend) begin
                            r_err <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_HANDOFF;
                        end
                    end
                end

                S_HANDOFF: begin
                    if (abort) begin
                        r_err <= 1'b1;
                        state <= S_FINISH;
                    end else if (digit_ack) begin
                        if (w_last_digit) begin
                            state <= S_FINISH;
                        end else begin
                            // Shift accumulates by addition and wraps mod 2^FSIZE.
                            r_d   <= r_d + 1'b1;
                            r_p   <= r_p + r_bit_cnt;
                            state <= S_START;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded straight from the state register; start_vector is
    // additionally gated so an abort in START suppresses the launch.
    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign start_vector = (state == S_START) && !abort;
    assign digit_valid  = (state == S_HANDOFF);
    assign done         = (state == S_FINISH);
    assign operation    = busy ? VECTOR_OPERATION_DECOMP_REDUCTION : 4'd0;
    assign p            = r_p;
    assign pq0          = r_pq0;
    assign digit_idx    = r_d;
    assign digit_cycles = r_digit_cycles;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decomp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decomp_sequencer
//  Description : Directed self-checking bench for decomp_sequencer with a
//                small behavioural model of the vector controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decomp_sequencer;

    localparam logic [3:0] c_op = 4'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_num_digits;
    logic [63:0] cmd_bit_cnt;
    logic [63:0] cmd_base_shift;
    logic        abort;
    logic        start_vector;
    logic [3:0]  operation;
    logic [63:0] p;
    logic [63:0] pq0;
    logic        vector_working;
    logic        digit_valid;
    logic [3:0]  digit_idx;
    logic [23:0] digit_cycles;
    logic        digit_ack;
    logic        done;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // controller model controls
    int vw_len   = 10;
    bit vw_never = 1'b0;
    int vw_rem;

    decomp_sequencer #(
        .FSIZE(64), .logD(4), .ARM_TIMEOUT(64), .CYC_W(24),
        .VECTOR_OPERATION_DECOMP_REDUCTION(c_op)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num_digits(cmd_num_digits), .cmd_bit_cnt(cmd_bit_cnt),
        .cmd_base_shift(cmd_base_shift), .abort(abort),
        .start_vector(start_vector), .operation(operation),
        .p(p), .pq0(pq0), .vector_working(vector_working),
        .digit_valid(digit_valid), .digit_idx(digit_idx),
        .digit_cycles(digit_cycles), .digit_ack(digit_ack),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: vector_working rises the cycle after start_vector
    // and stays high for vw_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            vector_working <= 1'b0;
            vw_rem         <= 0;
        end else if (start_vector && !vw_never) begin
            vector_working <= 1'b1;
            vw_rem         <= vw_len - 1;
        end else if (vector_working) begin
            if (vw_rem == 0) vector_working <= 1'b0;
            else             vw_rem <= vw_rem - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (digit_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(tag, {63'd0, ok}, 64'd1);
    endtask

    task automatic offer(input logic [3:0] nd, input logic [63:0] bc, input logic [63:0] bs);
        cmd_valid      = 1'b1;
        cmd_num_digits = nd;
        cmd_bit_cnt    = bc;
        cmd_base_shift = bs;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int s;
        bit flag;
        rst = 1'b1; cmd_valid = 1'b0; cmd_num_digits = '0; cmd_bit_cnt = '0;
        cmd_base_shift = '0; abort = 1'b0; digit_ack = 1'b0;
        repeat (3) step();

        // ---- reset values
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_op", operation, 0);
        chk("rst_p", p, 0);
        chk("rst_pq0", pq0, 0);
        chk("rst_sv", start_vector, 0);
        chk("rst_dv", digit_valid, 0);
        chk("rst_dcyc", digit_cycles, 0);
        rst = 1'b0;
        step();

        // ---- three digits, 10-cycle controller, immediate ack
        vw_len = 10;
        offer(4'd3, 64'd20, 64'd4);
        chk("t1_busy", busy, 1);
        chk("t1_op", operation, c_op);
        chk("t1_ready", cmd_ready, 0);
        for (int d = 0; d < 3; d++) begin
            chk("t1_sv", start_vector, 1);
            chk("t1_p", p, 64'(4 + 20 * d));
            chk("t1_pq0", pq0, 20);
            s = cyc;
            wait_valid("t1_wait", 40);
            chk("t1_lat", 64'(cyc - s), 12);
            chk("t1_idx", digit_idx, 64'(d));
            chk("t1_dcyc", digit_cycles, 12);
            digit_ack = 1'b1;
            step();
            digit_ack = 1'b0;
        end
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", cmd_ready, 1);

        // ---- bit_cnt=0 rejected; cmd_valid held through FINISH is not taken
        cmd_valid = 1'b1; cmd_num_digits = 4'd2; cmd_bit_cnt = 64'd0; cmd_base_shift = 64'd7;
        step();
        cmd_num_digits = 4'd0; cmd_bit_cnt = 64'd5;
        chk("t2_done", done, 1);
        chk("t2_err", err, 1);
        chk("t2_sv", start_vector, 0);
        chk("t2_ready_fin", cmd_ready, 0);
        step();
        chk("t2_idle", cmd_ready, 1);
        chk("t2_err_hold", err, 1);
        chk("t2_done_low", done, 0);
        step();
        cmd_valid = 1'b0;
        // ---- num_digits=0 completes cleanly
        chk("t2b_done", done, 1);
        chk("t2b_err", err, 0);
        chk("t2b_sv", start_vector, 0);
        chk("t2b_p_kept", p, 44);
        step();

        // ---- arm timeout
        vw_never = 1'b1;
        offer(4'd1, 64'd8, 64'd0);
        chk("t3_sv", start_vector, 1);
        step();                       // first ARM cycle
        repeat (63) step();
        chk("t3_done_early", done, 0);
        chk("t3_busy", busy, 1);
        step();
        chk("t3_done", done, 1);
        chk("t3_err", err, 1);
        step();
        vw_never = 1'b0;

        // ---- abort mid-RUN is deferred to the end of the digit
        vw_len = 10;
        offer(4'd2, 64'd4, 64'd1);
        chk("t4_sv", start_vector, 1);
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        flag = 1'b1;
        repeat (6) begin
            if (digit_valid !== 1'b0 || done !== 1'b0) flag = 1'b0;
            step();
        end
        chk("t4_quiet", {63'd0, flag}, 1);
        chk("t4_done", done, 1);
        chk("t4_err", err, 1);
        chk("t4_dv", digit_valid, 0);
        step();

        // ---- abort in HANDOFF
        vw_len = 3;
        offer(4'd2, 64'd4, 64'd1);
        wait_valid("t5_wait", 20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        step();

        // ---- abort in START suppresses the launch
        offer(4'd1, 64'd4, 64'd1);
        abort = 1'b1;
        #1;
        chk("t6_sv_masked", start_vector, 0);
        step();
        abort = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_err", err, 1);
        chk("t6_vw", vector_working, 0);
        step();

        // ---- delayed ack, shift wrap-around
        vw_len = 4;
        offer(4'd2, 64'd16, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t7_p0", p, 64'hFFFF_FFFF_FFFF_FFF8);
        wait_valid("t7_wait", 20);
        chk("t7_dcyc", digit_cycles, 6);
        flag = 1'b1;
        repeat (50) begin
            step();
            if (digit_valid !== 1'b1 || digit_idx !== 4'd0 ||
                p !== 64'hFFFF_FFFF_FFFF_FFF8 || start_vector !== 1'b0) flag = 1'b0;
        end
        chk("t7_hold", {63'd0, flag}, 1);
        digit_ack = 1'b1;
        step();
        digit_ack = 1'b0;
        chk("t7_sv", start_vector, 1);
        chk("t7_p1_wrap", p, 64'd8);
        wait_valid("t7_wait2", 20);
        chk("t7_idx1", digit_idx, 1);
        digit_ack = 1'b1;
        step();
        digit_ack = 1'b0;
        chk("t7_done", done, 1);
        chk("t7_err", err, 0);
        step();

        // ---- reset during RUN, then a fresh command
        vw_len = 10;
        offer(4'd2, 64'd20, 64'd4);
        repeat (3) step();
        chk("t8_busy_pre", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t8_ready", cmd_ready, 1);
        chk("t8_busy", busy, 0);
        chk("t8_p", p, 0);
        chk("t8_pq0", pq0, 0);
        chk("t8_dcyc", digit_cycles, 0);
        chk("t8_op", operation, 0);
        chk("t8_done", done, 0);
        step();
        vw_len = 2;
        offer(4'd1, 64'd2, 64'd3);
        chk("t8_sv", start_vector, 1);
        chk("t8_p_new", p, 3);
        wait_valid("t8_wait", 20);
        chk("t8_dcyc_new", digit_cycles, 4);
        digit_ack = 1'b1;
        step();
        digit_ack = 1'b0;
        chk("t8_done_new", done, 1);
        chk("t8_err_new", err, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
